hub75_receiver: RTL

HUB75_RECEIVER -- requirements
Module: hub75_receiver

---
 rtl/hub75_receiver.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/hub75_receiver.sv
// HUB75 LED-panel bus receiver: synchronizes the panel interface into clk_in,
// shifts pixels into a working row buffer and hands each latched row to a
// consumer over a valid/ready handshake, together with the OE-low cycle count.
module hub75_receiver #(
    parameter int unsigned NUM_COLS  = 64,
    parameter int unsigned SCAN_RATE = 32,
    localparam int unsigned AddrW    = $clog2(SCAN_RATE),
    localparam int unsigned RowW     = 3 * NUM_COLS
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             hub75_clk,
    input  logic             hub75_latch,
    input  logic             hub75_oe,
    input  logic [2:0]       hub75_rgb0,
    input  logic [2:0]       hub75_rgb1,
    input  logic [AddrW-1:0] hub75_addr,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [AddrW-1:0] row_addr,
    output logic [RowW-1:0]  row_rgb0,
    output logic [RowW-1:0]  row_rgb1,
    output logic [15:0]      row_oe_cycles,
    output logic             length_err,
    output logic             overflow
);

    localparam int unsigned ColW = $clog2(NUM_COLS) + 1;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    // Synchronizer stages (s1/s2) plus delayed copy (s3) for edge detection
    logic             clk_s1_q, clk_s2_q, clk_s3_q;
    logic             latch_s1_q, latch_s2_q, latch_s3_q;
    logic             oe_s1_q, oe_s2_q;
    logic [2:0]       rgb0_s1_q, rgb0_s2_q, rgb1_s1_q, rgb1_s2_q;
    logic [AddrW-1:0] addr_s1_q, addr_s2_q;

    // Registered events with the data that belongs to them
    logic             shift_evt_q, latch_evt_q, oe_p_q;
    logic [2:0]       rgb0_p_q, rgb1_p_q;
    logic [AddrW-1:0] addr_p_q;

    // Events are ignored until the pipeline holds only post-reset samples,
    // so a panel clock already high at reset release is not seen as an edge.
    logic [2:0] warm_q, warm_d;
    logic       en;

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
    logic [15:0]       oe_cnt_q, oe_cnt_d;
    logic              row_valid_q, row_valid_d;
    logic [AddrW-1:0]  row_addr_q, row_addr_d;
    logic [RowW-1:0]   row_rgb0_q, row_rgb0_d, row_rgb1_q, row_rgb1_d;
    logic [15:0]       row_oe_q, row_oe_d;
    logic              length_err_q, length_err_d;
    logic              overflow_q, overflow_d;

    logic shift, latch, accept;

    // Input synchronizers, edge detection and event pipeline
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clk_s1_q    <= 1'b0;
            clk_s2_q    <= 1'b0;
            clk_s3_q    <= 1'b0;
            latch_s1_q  <= 1'b0;
            latch_s2_q  <= 1'b0;
            latch_s3_q  <= 1'b0;
            oe_s1_q     <= 1'b0;
            oe_s2_q     <= 1'b0;
            rgb0_s1_q   <= '0;
            rgb0_s2_q   <= '0;
            rgb1_s1_q   <= '0;
            rgb1_s2_q   <= '0;
            addr_s1_q   <= '0;
            addr_s2_q   <= '0;
            shift_evt_q <= 1'b0;
            latch_evt_q <= 1'b0;
            oe_p_q      <= 1'b0;
            rgb0_p_q    <= '0;
            rgb1_p_q    <= '0;
            addr_p_q    <= '0;
        end else begin
            clk_s1_q    <= hub75_clk;
            clk_s2_q    <= clk_s1_q;
            clk_s3_q    <= clk_s2_q;
            latch_s1_q  <= hub75_latch;
            latch_s2_q  <= latch_s1_q;
            latch_s3_q  <= latch_s2_q;
            oe_s1_q     <= hub75_oe;
            oe_s2_q     <= oe_s1_q;
            rgb0_s1_q   <= hub75_rgb0;
            rgb0_s2_q   <= rgb0_s1_q;
            rgb1_s1_q   <= hub75_rgb1;
            rgb1_s2_q   <= rgb1_s1_q;
            addr_s1_q   <= hub75_addr;
            addr_s2_q   <= addr_s1_q;
            shift_evt_q <= clk_s2_q & ~clk_s3_q;
            latch_evt_q <= latch_s2_q & ~latch_s3_q;
            oe_p_q      <= oe_s2_q;
            rgb0_p_q    <= rgb0_s2_q;
            rgb1_p_q    <= rgb1_s2_q;
            addr_p_q    <= addr_s2_q;
        end
    end

    // Capture state, row output registers and sticky flags
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            warm_q       <= '0;
            state_q      <= StIdle;
            col_q        <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            oe_cnt_q     <= '0;
            row_valid_q  <= 1'b0;
            row_addr_q   <= '0;
            row_rgb0_q   <= '0;
            row_rgb1_q   <= '0;
            row_oe_q     <= '0;
            length_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            warm_q       <= warm_d;
            state_q      <= state_d;
            col_q        <= col_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            oe_cnt_q     <= oe_cnt_d;
            row_valid_q  <= row_valid_d;
            row_addr_q   <= row_addr_d;
            row_rgb0_q   <= row_rgb0_d;
            row_rgb1_q   <= row_rgb1_d;
            row_oe_q     <= row_oe_d;
            length_err_q <= length_err_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state: shift into the working buffer, then handle latch and handshake
    always_comb begin
        warm_d       = warm_q;
        state_d      = state_q;
        col_d        = col_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        oe_cnt_d     = oe_cnt_q;
        row_valid_d  = row_valid_q;
        row_addr_d   = row_addr_q;
        row_rgb0_d   = row_rgb0_q;
        row_rgb1_d   = row_rgb1_q;
        row_oe_d     = row_oe_q;
        length_err_d = length_err_q;
        overflow_d   = overflow_q;

        en = (warm_q == 3'd4);
        if (!en) begin
            warm_d = warm_q + 3'd1;
        end
        shift  = en && shift_evt_q;
        latch  = en && latch_evt_q;
        accept = row_valid_q && row_ready;

        if (en && !oe_p_q && oe_cnt_q != 16'hFFFF) begin
            oe_cnt_d = oe_cnt_q + 16'd1;
        end

        // Shift is applied first so a coincident latch includes its pixel
        if (shift) begin
            state_d = StFill;
            if (col_q < ColW'(NUM_COLS)) begin
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    if (col_q == ColW'(c)) begin
                        buf0_d[3*c +: 3] = rgb0_p_q;
                        buf1_d[3*c +: 3] = rgb1_p_q;
                    end
                end
                col_d = col_q + ColW'(1);
            end else begin
                col_d = ColW'(NUM_COLS + 1);
            end
        end

        if (accept) begin
            row_valid_d = 1'b0;
        end

        if (latch) begin
            if (!row_valid_q || accept) begin
                row_valid_d = 1'b1;
                row_addr_d  = addr_p_q;
                row_rgb0_d  = buf0_d;
                row_rgb1_d  = buf1_d;
                row_oe_d    = oe_cnt_q;
            end else begin
                overflow_d = 1'b1;
            end
            if ((state_q == StIdle && !shift) || col_d != ColW'(NUM_COLS)) begin
                length_err_d = 1'b1;
            end
            state_d  = StIdle;
            col_d    = '0;
            buf0_d   = '0;
            buf1_d   = '0;
            oe_cnt_d = '0;
        end
    end

    assign row_valid     = row_valid_q;
    assign row_addr      = row_addr_q;
    assign row_rgb0      = row_rgb0_q;
    assign row_rgb1      = row_rgb1_q;
    assign row_oe_cycles = row_oe_q;
    assign length_err    = length_err_q;
    assign overflow      = overflow_q;

endmodule
